// File: rtl/layer_mem_responder.sv
// Layer-memory responder for the convolution engine.
// Holds the layer-0 (conv+ReLU) and layer-1 (maxpool) result banks, serves
// engine writes and zero-latency reads, and streams one bank at a time out
// over a valid/ready dump port for host readback.
//
// Dump FSM states
//   state    | meaning
//   S_IDLE   | no dump in progress, dump_start accepted here only
//   S_STREAM | beats presented on dump_*; advance on valid && ready
//   S_DONE   | last beat accepted, dump_done pulses for this one cycle
module layer_mem_responder #(
   parameter int DW       = 20,
   parameter int AW       = 12,
   parameter int L0_DEPTH = 4096,
   parameter int L1_DEPTH = 1024
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          cwr,
   input  logic [AW-1:0]                 caddr_wr,
   input  logic [DW-1:0]                 cdata_wr,
   input  logic                          crd,
   input  logic [AW-1:0]                 caddr_rd,
   output logic [DW-1:0]                 cdata_rd,
   input  logic [2:0]                    csel,
   input  logic                          dump_start,
   input  logic [2:0]                    dump_sel,
   output logic                          dump_valid,
   input  logic                          dump_ready,
   output logic [AW-1:0]                 dump_addr,
   output logic [DW-1:0]                 dump_data,
   output logic                          dump_last,
   output logic                          dump_done,
   output logic [$clog2(L0_DEPTH):0]     wr_cnt_l0,
   output logic [$clog2(L1_DEPTH):0]     wr_cnt_l1,
   output logic                          sel_err
);

   localparam int L0_AW = $clog2(L0_DEPTH);
   localparam int L1_AW = $clog2(L1_DEPTH);

   localparam logic [2:0] SEL_L0 = 3'b001;
   localparam logic [2:0] SEL_L1 = 3'b011;

   localparam logic [AW-1:0] L0_LAST = AW'(L0_DEPTH - 1);
   localparam logic [AW-1:0] L1_LAST = AW'(L1_DEPTH - 1);

   localparam logic [L0_AW:0] L0_CNT_MAX = (L0_AW+1)'(L0_DEPTH);
   localparam logic [L1_AW:0] L1_CNT_MAX = (L1_AW+1)'(L1_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   logic [DW-1:0] mem_l0 [L0_DEPTH];
   logic [DW-1:0] mem_l1 [L1_DEPTH];

   state_t          state_q, state_d;
   logic            bank_q, bank_d;        // 0 = layer-0 bank, 1 = layer-1 bank
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   data_q, data_d;
   logic            valid_q, valid_d;
   logic            sel_err_q, sel_err_d;
   logic [L0_AW:0]  wr_cnt_l0_q, wr_cnt_l0_d;
   logic [L1_AW:0]  wr_cnt_l1_q, wr_cnt_l1_d;

   logic            csel_l0, csel_l1, csel_ok;
   logic            dsel_l0, dsel_l1, dsel_ok;
   logic            wr_l0, wr_l1;
   logic            dump_rd_bank;
   logic [AW-1:0]   dump_rd_addr;
   logic [DW-1:0]   dump_rd_data;
   logic [AW-1:0]   last_addr;

   assign csel_l0 = (csel == SEL_L0);
   assign csel_l1 = (csel == SEL_L1);
   assign csel_ok = csel_l0 | csel_l1;
   assign dsel_l0 = (dump_sel == SEL_L0);
   assign dsel_l1 = (dump_sel == SEL_L1);
   assign dsel_ok = dsel_l0 | dsel_l1;

   assign wr_l0 = cwr & csel_l0;
   assign wr_l1 = cwr & csel_l1;

   // Engine write port; layer-1 only looks at the low address bits.
   always_ff @(posedge clk) begin
      if (wr_l0) mem_l0[caddr_wr[L0_AW-1:0]] <= cdata_wr;
      if (wr_l1) mem_l1[caddr_wr[L1_AW-1:0]] <= cdata_wr;
   end

   // Engine read port: combinational, reads pre-edge contents so a same-cycle
   // write to the same entry is seen only from the following cycle.
   always_comb begin
      cdata_rd = '0;
      if (crd && csel_l0)      cdata_rd = mem_l0[caddr_rd[L0_AW-1:0]];
      else if (crd && csel_l1) cdata_rd = mem_l1[caddr_rd[L1_AW-1:0]];
   end

   // Dump read port addresses the beat about to be loaded: entry 0 of the
   // requested bank when starting, otherwise the entry after the current one.
   assign dump_rd_bank = (state_q == S_IDLE) ? dsel_l1 : bank_q;
   assign dump_rd_addr = (state_q == S_IDLE) ? '0 : addr_q + AW'(1);
   assign dump_rd_data = dump_rd_bank ? mem_l1[dump_rd_addr[L1_AW-1:0]]
                                      : mem_l0[dump_rd_addr[L0_AW-1:0]];

   assign last_addr = bank_q ? L1_LAST : L0_LAST;

   // Dump FSM next-state and beat register updates.
   always_comb begin
      state_d = state_q;
      bank_d  = bank_q;
      addr_d  = addr_q;
      data_d  = data_q;
      valid_d = valid_q;
      case (state_q)
         S_IDLE: begin
            if (dump_start && dsel_ok) begin
               bank_d  = dsel_l1;
               addr_d  = '0;
               data_d  = dump_rd_data;
               valid_d = 1'b1;
               state_d = S_STREAM;
            end
         end
         S_STREAM: begin
            if (valid_q && dump_ready) begin
               if (addr_q == last_addr) begin
                  valid_d = 1'b0;
                  state_d = S_DONE;
               end else begin
                  addr_d = dump_rd_addr;
                  data_d = dump_rd_data;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   // Sticky select error and saturating per-bank write counters.
   always_comb begin
      sel_err_d = sel_err_q;
      if (((cwr || crd) && !csel_ok) ||
          (state_q == S_IDLE && dump_start && !dsel_ok))
         sel_err_d = 1'b1;

      wr_cnt_l0_d = wr_cnt_l0_q;
      if (wr_l0 && wr_cnt_l0_q != L0_CNT_MAX) wr_cnt_l0_d = wr_cnt_l0_q + 1'b1;

      wr_cnt_l1_d = wr_cnt_l1_q;
      if (wr_l1 && wr_cnt_l1_q != L1_CNT_MAX) wr_cnt_l1_d = wr_cnt_l1_q + 1'b1;
   end

   // Control and status registers; bank contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         bank_q      <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         sel_err_q   <= 1'b0;
         wr_cnt_l0_q <= '0;
         wr_cnt_l1_q <= '0;
      end else begin
         state_q     <= state_d;
         bank_q      <= bank_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         sel_err_q   <= sel_err_d;
         wr_cnt_l0_q <= wr_cnt_l0_d;
         wr_cnt_l1_q <= wr_cnt_l1_d;
      end
   end

   assign dump_valid = valid_q;
   assign dump_addr  = addr_q;
   assign dump_data  = data_q;
   assign dump_last  = valid_q && (addr_q == last_addr);
   assign dump_done  = (state_q == S_DONE);
   assign wr_cnt_l0  = wr_cnt_l0_q;
   assign wr_cnt_l1  = wr_cnt_l1_q;
   assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_layer_mem_responder.sv
// Scoreboard bench for layer_mem_responder: stimulus pushes expected read
// data and dump beats into queues, a negedge monitor pops and compares.
module tb_layer_mem_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cwr = 1'b0;
   logic [11:0] caddr_wr = '0;
   logic [19:0] cdata_wr = '0;
   logic        crd = 1'b0;
   logic [11:0] caddr_rd = '0;
   logic [19:0] cdata_rd;
   logic [2:0]  csel = 3'b001;
   logic        dump_start = 1'b0;
   logic [2:0]  dump_sel = 3'b001;
   logic        dump_valid;
   logic        dump_ready = 1'b0;
   logic [11:0] dump_addr;
   logic [19:0] dump_data;
   logic        dump_last;
   logic        dump_done;
   logic [12:0] wr_cnt_l0;
   logic [10:0] wr_cnt_l1;
   logic        sel_err;

   layer_mem_responder dut (
      .clk(clk), .reset(reset),
      .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
      .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
      .csel(csel),
      .dump_start(dump_start), .dump_sel(dump_sel),
      .dump_valid(dump_valid), .dump_ready(dump_ready),
      .dump_addr(dump_addr), .dump_data(dump_data),
      .dump_last(dump_last), .dump_done(dump_done),
      .wr_cnt_l0(wr_cnt_l0), .wr_cnt_l1(wr_cnt_l1),
      .sel_err(sel_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] a;
      logic [19:0] d;
      logic        l;
   } beat_t;

   logic [19:0] rd_q[$];
   beat_t       dump_q[$];
   logic [19:0] l0_model [4096];
   logic [19:0] l1_model [1024];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_cyc = -10;
   int done_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: compares engine reads and accepted dump beats against the queues.
   always @(negedge clk) begin
      if (crd === 1'b1) begin
         checks++;
         if (rd_q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected: got %0h expected no read", cdata_rd);
         end else begin
            logic [19:0] e;
            e = rd_q.pop_front();
            if (cdata_rd !== e) begin
               errors++;
               $display("FAIL cdata_rd: got %0h expected %0h (t=%0t)", cdata_rd, e, $time);
            end
         end
      end
      if (dump_valid === 1'b1 && dump_ready === 1'b1) begin
         checks++;
         if (dump_q.size() == 0) begin
            errors++;
            $display("FAIL dump_unexpected: got addr %0h expected no beat", dump_addr);
         end else begin
            beat_t b;
            b = dump_q.pop_front();
            if (dump_addr !== b.a || dump_data !== b.d || dump_last !== b.l) begin
               errors++;
               $display("FAIL dump_beat: got a=%0h d=%0h l=%0b expected a=%0h d=%0h l=%0b",
                        dump_addr, dump_data, dump_last, b.a, b.d, b.l);
            end
         end
         if (dump_last === 1'b1) last_cyc = cyc;
      end
      if (dump_done === 1'b1) begin
         done_cnt++;
         checks++;
         if (cyc != last_cyc + 1) begin
            errors++;
            $display("FAIL dump_done_timing: got cycle %0d expected %0d", cyc, last_cyc + 1);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [19:0] f0(input int a);
      return 20'h80000 | 20'(a);
   endfunction

   task automatic wr(input logic [2:0] s, input logic [11:0] a, input logic [19:0] d);
      cwr = 1'b1; csel = s; caddr_wr = a; cdata_wr = d;
      if (s == 3'b001) l0_model[a] = d;
      if (s == 3'b011) l1_model[a[9:0]] = d;
      step();
      cwr = 1'b0;
   endtask

   task automatic rd(input logic [2:0] s, input logic [11:0] a, input logic [19:0] e);
      crd = 1'b1; csel = s; caddr_rd = a;
      rd_q.push_back(e);
      step();
      crd = 1'b0;
   endtask

   task automatic start_dump(input logic [2:0] s);
      int n;
      beat_t b;
      n = (s == 3'b011) ? 1024 : 4096;
      for (int i = 0; i < n; i++) begin
         b.a = 12'(i);
         b.d = (s == 3'b011) ? l1_model[i] : l0_model[i];
         b.l = (i == n - 1);
         dump_q.push_back(b);
      end
      dump_start = 1'b1; dump_sel = s;
      step();
      dump_start = 1'b0;
   endtask

   task automatic finish_dump(input int max_cyc, input bit toggle);
      int start;
      int n;
      start = done_cnt;
      n = 0;
      while (done_cnt == start && n < max_cyc) begin
         if (toggle) dump_ready = !dump_ready;
         step();
         n++;
      end
      chk("dump_done_count", 32'(done_cnt - start), 32'd1);
      chk("dump_q_drained", 32'(dump_q.size()), 32'd0);
      dump_ready = 1'b0;
   endtask

   initial begin
      int n;
      int start;

      repeat (3) step();
      reset = 1'b0;
      chk("rst_dump_valid", 32'(dump_valid), 32'd0);
      chk("rst_dump_done", 32'(dump_done), 32'd0);
      chk("rst_dump_last", 32'(dump_last), 32'd0);
      chk("rst_dump_addr", 32'(dump_addr), 32'd0);
      chk("rst_dump_data", 32'(dump_data), 32'd0);
      chk("rst_sel_err", 32'(sel_err), 32'd0);
      chk("rst_wr_cnt_l0", 32'(wr_cnt_l0), 32'd0);
      chk("rst_wr_cnt_l1", 32'(wr_cnt_l1), 32'd0);
      chk("rst_cdata_rd", 32'(cdata_rd), 32'd0);

      // 1: write then read back in L0
      wr(3'b001, 12'd5, 20'h00ABC);
      chk("t1_wr_cnt_l0", 32'(wr_cnt_l0), 32'd1);
      rd(3'b001, 12'd5, 20'h00ABC);

      // 2: same-cycle write and read of one L1 entry returns old data
      wr(3'b011, 12'd7, 20'h00001);
      cwr = 1'b1; csel = 3'b011; caddr_wr = 12'd7; cdata_wr = 20'h12345;
      crd = 1'b1; caddr_rd = 12'd7;
      l1_model[7] = 20'h12345;
      rd_q.push_back(20'h00001);
      step();
      cwr = 1'b0;
      rd_q.push_back(20'h12345);
      step();
      crd = 1'b0;

      // 3: L1 address aliasing and invalid select
      wr(3'b011, 12'hFFF, 20'h55555);
      rd(3'b011, 12'h3FF, 20'h55555);
      rd(3'b011, 12'hFFF, 20'h55555);
      chk("t3_wr_cnt_l1", 32'(wr_cnt_l1), 32'd3);
      chk("t3_sel_err_before", 32'(sel_err), 32'd0);
      rd(3'b010, 12'd7, 20'h00000);
      chk("t3_sel_err", 32'(sel_err), 32'd1);

      // 4: fill L1 with data=addr, dump with toggling ready
      for (int i = 0; i < 1024; i++) wr(3'b011, 12'(i), 20'(i));
      chk("t4_wr_cnt_l1_sat", 32'(wr_cnt_l1), 32'd1024);
      start_dump(3'b011);
      chk("t4_dump_valid", 32'(dump_valid), 32'd1);
      finish_dump(3000, 1'b1);
      chk("t4_idle_after_done", 32'(dump_valid), 32'd0);

      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_rst_sel_err", 32'(sel_err), 32'd0);
      chk("mid_rst_wr_cnt_l1", 32'(wr_cnt_l1), 32'd0);

      // 5: L0 write counter saturation
      for (int i = 0; i <= 4096; i++) begin
         wr(3'b001, 12'(i), f0(i % 4096));
         if (i == 4094) chk("t5_cnt_4095", 32'(wr_cnt_l0), 32'd4095);
         if (i == 4095) chk("t5_cnt_4096", 32'(wr_cnt_l0), 32'd4096);
         if (i == 4096) chk("t5_cnt_sat", 32'(wr_cnt_l0), 32'd4096);
      end

      // 5b: L0 dump with ignored dump_start and a write to the next beat
      start_dump(3'b001);
      dump_ready = 1'b1;
      start = done_cnt;
      n = 0;
      while (done_cnt == start && n < 6000) begin
         dump_start = 1'b0;
         cwr = 1'b0;
         if (dump_valid && dump_addr == 12'd50) begin
            dump_start = 1'b1; dump_sel = 3'b111;
         end
         if (dump_valid && dump_addr == 12'd60) begin
            dump_start = 1'b1; dump_sel = 3'b011;
         end
         if (dump_valid && dump_addr == 12'd100) begin
            cwr = 1'b1; csel = 3'b001; caddr_wr = 12'd101; cdata_wr = 20'h7AAAA;
            l0_model[101] = 20'h7AAAA;
         end
         step();
         n++;
      end
      dump_start = 1'b0;
      cwr = 1'b0;
      chk("t5_dump_done_count", 32'(done_cnt - start), 32'd1);
      chk("t5_dump_q_drained", 32'(dump_q.size()), 32'd0);
      chk("t5_no_sel_err", 32'(sel_err), 32'd0);
      rd(3'b001, 12'd101, 20'h7AAAA);
      rd(3'b001, 12'hFFF, f0(4095));

      // 6: reset in the middle of an L0 dump
      start_dump(3'b001);
      dump_ready = 1'b1;
      n = 0;
      while (!(dump_valid && dump_addr == 12'd300) && n < 1000) begin
         step();
         n++;
      end
      chk("t6_reached_beat300", 32'(dump_addr), 32'd300);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t6_valid_after_rst", 32'(dump_valid), 32'd0);
      dump_q.delete();
      start = done_cnt;
      repeat (5) step();
      chk("t6_no_done", 32'(done_cnt - start), 32'd0);
      chk("t6_dump_addr", 32'(dump_addr), 32'd0);
      chk("t6_dump_data", 32'(dump_data), 32'd0);
      chk("t6_wr_cnt_l0", 32'(wr_cnt_l0), 32'd0);
      dump_ready = 1'b0;
      start_dump(3'b001);
      chk("t6_restart_addr", 32'(dump_addr), 32'd0);
      finish_dump(10000, 1'b1);

      chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
